axi_arbiter: RTL and testbench

AXI_ARBITER -- requirements
Module: axi_arbiter

---
 rtl/axi_arbiter.sv | 174 +++++++++++++++++
 tb/tb_axi_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_arbiter.sv
// rtl/axi_arbiter.sv - two-master AXI4 arbiter (m0 read-only, m1 read/write) onto one downstream port
// Round-robin between masters, one downstream transaction outstanding at a time.
module axi_arbiter (
    input  logic        clock,
    input  logic        reset,
    // master 0 (IFU) read channels
    input  logic        m0_arvalid,
    input  logic [31:0] m0_araddr,
    input  logic [3:0]  m0_arid,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    output logic        m0_arready,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic [3:0]  m0_rid,
    output logic        m0_rlast,
    input  logic        m0_rready,
    // master 1 (LSU) read channels
    input  logic        m1_arvalid,
    input  logic [31:0] m1_araddr,
    input  logic [3:0]  m1_arid,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    output logic        m1_arready,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic [3:0]  m1_rid,
    output logic        m1_rlast,
    input  logic        m1_rready,
    // master 1 write channels
    input  logic        m1_awvalid,
    input  logic [31:0] m1_awaddr,
    input  logic [3:0]  m1_awid,
    input  logic [7:0]  m1_awlen,
    input  logic [2:0]  m1_awsize,
    input  logic [1:0]  m1_awburst,
    output logic        m1_awready,
    input  logic        m1_wvalid,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wlast,
    output logic        m1_wready,
    output logic        m1_bvalid,
    output logic [1:0]  m1_bresp,
    output logic [3:0]  m1_bid,
    input  logic        m1_bready,
    // downstream port
    output logic        s_arvalid,
    output logic [31:0] s_araddr,
    output logic [3:0]  s_arid,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    input  logic        s_arready,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic [3:0]  s_rid,
    input  logic        s_rlast,
    output logic        s_rready,
    output logic        s_awvalid,
    output logic [31:0] s_awaddr,
    output logic [3:0]  s_awid,
    output logic [7:0]  s_awlen,
    output logic [2:0]  s_awsize,
    output logic [1:0]  s_awburst,
    input  logic        s_awready,
    output logic        s_wvalid,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wlast,
    input  logic        s_wready,
    input  logic        s_bvalid,
    input  logic [1:0]  s_bresp,
    input  logic [3:0]  s_bid,
    output logic        s_bready
);

    typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_t;

    state_t state_q;
    logic   ar_done_q;
    logic   aw_done_q;
    logic   last_grant_q;   // 0: m0 was granted last, 1: m1 was granted last

    logic   req1;
    assign req1 = m1_arvalid | m1_awvalid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_arvalid && (!req1 || last_grant_q)) begin
                        state_q      <= RD0;
                        last_grant_q <= 1'b0;
                    end else if (req1) begin
                        // m1 read takes precedence over m1 write
                        state_q      <= m1_arvalid ? RD1 : WR1;
                        last_grant_q <= 1'b1;
                    end
                end
                RD0, RD1: begin
                    if (s_arvalid && s_arready) ar_done_q <= 1'b1;
                    if (s_rvalid && s_rready && s_rlast) begin
                        state_q   <= IDLE;
                        ar_done_q <= 1'b0;
                    end
                end
                WR1: begin
                    if (s_awvalid && s_awready) aw_done_q <= 1'b1;
                    if (s_bvalid && s_bready) begin
                        state_q   <= IDLE;
                        aw_done_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_rready  = 1'b0;
        s_awvalid = 1'b0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_wvalid  = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0;
        s_bready  = 1'b0;
        m0_arready = 1'b0; m0_rvalid = 1'b0; m0_rdata = '0; m0_rresp = '0; m0_rid = '0; m0_rlast = 1'b0;
        m1_arready = 1'b0; m1_rvalid = 1'b0; m1_rdata = '0; m1_rresp = '0; m1_rid = '0; m1_rlast = 1'b0;
        m1_awready = 1'b0; m1_wready = 1'b0;
        m1_bvalid  = 1'b0; m1_bresp = '0; m1_bid = '0;
        case (state_q)
            RD0: begin
                s_arvalid  = m0_arvalid & ~ar_done_q;
                s_araddr   = m0_araddr;  s_arid   = m0_arid;   s_arlen = m0_arlen;
                s_arsize   = m0_arsize;  s_arburst = m0_arburst;
                m0_arready = s_arready & ~ar_done_q;
                m0_rvalid  = s_rvalid;   m0_rdata = s_rdata;   m0_rresp = s_rresp;
                m0_rid     = s_rid;      m0_rlast = s_rlast;
                s_rready   = m0_rready;
            end
            RD1: begin
                s_arvalid  = m1_arvalid & ~ar_done_q;
                s_araddr   = m1_araddr;  s_arid   = m1_arid;   s_arlen = m1_arlen;
                s_arsize   = m1_arsize;  s_arburst = m1_arburst;
                m1_arready = s_arready & ~ar_done_q;
                m1_rvalid  = s_rvalid;   m1_rdata = s_rdata;   m1_rresp = s_rresp;
                m1_rid     = s_rid;      m1_rlast = s_rlast;
                s_rready   = m1_rready;
            end
            WR1: begin
                s_awvalid  = m1_awvalid & ~aw_done_q;
                s_awaddr   = m1_awaddr;  s_awid   = m1_awid;   s_awlen = m1_awlen;
                s_awsize   = m1_awsize;  s_awburst = m1_awburst;
                m1_awready = s_awready & ~aw_done_q;
                // W beats are independent of AW progress
                s_wvalid   = m1_wvalid;  s_wdata  = m1_wdata;  s_wstrb = m1_wstrb; s_wlast = m1_wlast;
                m1_wready  = s_wready;
                m1_bvalid  = s_bvalid;   m1_bresp = s_bresp;   m1_bid  = s_bid;
                s_bready   = m1_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// tb/tb_axi_arbiter.sv - randomized scoreboard bench for axi_arbiter
module tb_axi_arbiter;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
    logic [31:0] m0_araddr, m0_rdata;
    logic [3:0]  m0_arid, m0_rid;
    logic [7:0]  m0_arlen;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_arburst, m0_rresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
    logic [31:0] m1_araddr, m1_rdata;
    logic [3:0]  m1_arid, m1_rid;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_arburst, m1_rresp;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready, m1_bvalid, m1_bready;
    logic [31:0] m1_awaddr, m1_wdata;
    logic [3:0]  m1_awid, m1_wstrb, m1_bid;
    logic [7:0]  m1_awlen;
    logic [2:0]  m1_awsize;
    logic [1:0]  m1_awburst, m1_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic [31:0] s_araddr, s_rdata;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_awid, s_wstrb, s_bid;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, s_bresp;

    axi_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
        .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rid(m0_rid),
        .m0_rlast(m0_rlast), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
        .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rid(m1_rid),
        .m1_rlast(m1_rlast), .m1_rready(m1_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
        .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
        .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
        .m1_bready(m1_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid),
        .s_rlast(s_rlast), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid),
        .s_bready(s_bready)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard queues, filled by the master drivers when they issue a request
    logic [48:0] exp_ar0[$], exp_ar1[$], exp_aw[$];   // {burst,size,len,id,addr}
    logic [38:0] exp_r0[$], exp_r1[$];                 // {last,resp,id,data}
    logic [36:0] exp_w[$];                             // {last,strb,data}
    logic [5:0]  exp_b[$];                             // {resp,id}

    // Arbitration reference state: grant codes 0 = m0 read, 1 = m1 read, 2 = m1 write
    int  tb_last = 1;
    bit  txn_active = 0;
    int  txn_kind = 0;
    bit  exp_pending = 0;
    int  exp_g = 0;
    int  grant_log[$];
    bit  slave_rhold = 0;

    function automatic logic [31:0] rd_data(input logic [31:0] a, input int b);
        return (a + 32'(b) * 32'd4) ^ 32'h5A5A_0F0F;
    endfunction
    function automatic logic [31:0] wr_data(input logic [31:0] a, input int b);
        return ~(a + 32'(b) * 32'd4);
    endfunction
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return a[3:2];
    endfunction
    function automatic logic [11:0] quiet_vec();
        return {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m0_arready, m0_rvalid,
                m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Downstream slave: random readiness, data derived from the address
    initial begin
        logic [48:0] sl_rd[$], sl_aw[$];
        logic [5:0]  sl_b[$];
        int   beat, wl;
        bit   r_fire, b_fire, rst_seen;
        beat = 0; wl = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rid = 0; s_rlast = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0; s_bid = 0;
        forever begin
            @(negedge clock);
            r_fire = s_rvalid && s_rready;
            b_fire = s_bvalid && s_bready;
            rst_seen = reset;
            if (reset) begin
                sl_rd.delete(); sl_aw.delete(); sl_b.delete(); beat = 0; wl = 0;
            end else begin
                if (s_arvalid && s_arready) begin
                    if (s_arid[3]) begin
                        if (exp_ar1.size() == 0) chk("ar1_unexpected", 64'(s_araddr), 64'hFFFF_FFFF_FFFF);
                        else chk("ar1_fields", 64'({s_arburst, s_arsize, s_arlen, s_arid, s_araddr}), 64'(exp_ar1.pop_front()));
                    end else begin
                        if (exp_ar0.size() == 0) chk("ar0_unexpected", 64'(s_araddr), 64'hFFFF_FFFF_FFFF);
                        else chk("ar0_fields", 64'({s_arburst, s_arsize, s_arlen, s_arid, s_araddr}), 64'(exp_ar0.pop_front()));
                    end
                    sl_rd.push_back({s_arburst, s_arsize, s_arlen, s_arid, s_araddr});
                end
                if (r_fire && sl_rd.size() > 0) begin
                    beat++;
                    if (s_rlast) begin void'(sl_rd.pop_front()); beat = 0; end
                end
                if (s_awvalid && s_awready) begin
                    if (exp_aw.size() == 0) chk("aw_unexpected", 64'(s_awaddr), 64'hFFFF_FFFF_FFFF);
                    else chk("aw_fields", 64'({s_awburst, s_awsize, s_awlen, s_awid, s_awaddr}), 64'(exp_aw.pop_front()));
                    sl_aw.push_back({s_awburst, s_awsize, s_awlen, s_awid, s_awaddr});
                end
                if (s_wvalid && s_wready) begin
                    if (exp_w.size() == 0) chk("w_unexpected", 64'(s_wdata), 64'hFFFF_FFFF_FFFF);
                    else chk("w_beat", 64'({s_wlast, s_wstrb, s_wdata}), 64'(exp_w.pop_front()));
                    if (s_wlast) wl++;
                end
                if (sl_aw.size() > 0 && wl > 0) begin
                    sl_b.push_back({resp_of(sl_aw[0][31:0]), sl_aw[0][35:32]});
                    void'(sl_aw.pop_front());
                    wl--;
                end
            end
            @(posedge clock); #1;
            s_arready = 1'($urandom_range(0, 1));
            s_awready = 1'($urandom_range(0, 1));
            s_wready  = 1'($urandom_range(0, 1));
            if (rst_seen) begin
                s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rid = 0; s_rlast = 0;
                s_bvalid = 0; s_bresp = 0; s_bid = 0;
            end else begin
                if (!(s_rvalid && !r_fire)) begin
                    if (sl_rd.size() > 0 && !slave_rhold && $urandom_range(0, 3) != 0) begin
                        s_rvalid = 1;
                        s_rdata  = rd_data(sl_rd[0][31:0], beat);
                        s_rresp  = resp_of(sl_rd[0][31:0]);
                        s_rid    = sl_rd[0][35:32];
                        s_rlast  = (beat == int'(sl_rd[0][43:36]));
                    end else begin
                        s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rid = 0; s_rlast = 0;
                    end
                end
                if (!(s_bvalid && !b_fire)) begin
                    if (sl_b.size() > 0 && $urandom_range(0, 2) != 0) begin
                        s_bvalid = 1;
                        {s_bresp, s_bid} = sl_b.pop_front();
                    end else begin
                        s_bvalid = 0; s_bresp = 0; s_bid = 0;
                    end
                end
            end
        end
    end

    // Masters' response-side readiness
    initial begin
        m0_rready = 0; m1_rready = 0; m1_bready = 0;
        forever begin
            @(posedge clock); #1;
            m0_rready = ($urandom_range(0, 3) != 0);
            m1_rready = ($urandom_range(0, 3) != 0);
            m1_bready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: response scoreboard plus round-robin/one-outstanding reference model
    initial begin
        bit was_idle, start, r0, r1;
        int g;
        forever begin
            @(negedge clock);
            if (reset) begin
                txn_active = 0; exp_pending = 0; tb_last = 1;
            end else begin
                if (m0_rvalid && m0_rready) begin
                    if (exp_r0.size() == 0) chk("r0_unexpected", 64'(m0_rdata), 64'hFFFF_FFFF_FFFF);
                    else chk("r0_beat", 64'({m0_rlast, m0_rresp, m0_rid, m0_rdata}), 64'(exp_r0.pop_front()));
                end
                if (m1_rvalid && m1_rready) begin
                    if (exp_r1.size() == 0) chk("r1_unexpected", 64'(m1_rdata), 64'hFFFF_FFFF_FFFF);
                    else chk("r1_beat", 64'({m1_rlast, m1_rresp, m1_rid, m1_rdata}), 64'(exp_r1.pop_front()));
                end
                if (m1_bvalid && m1_bready) begin
                    if (exp_b.size() == 0) chk("b_unexpected", 64'({m1_bresp, m1_bid}), 64'hFF);
                    else chk("b_resp", 64'({m1_bresp, m1_bid}), 64'(exp_b.pop_front()));
                end
                was_idle = !txn_active;
                start = was_idle && (s_arvalid || s_awvalid);
                g = 3;
                if (start) g = s_arvalid ? (s_arid[3] ? 1 : 0) : 2;
                if (exp_pending) begin
                    chk("grant", 64'(g), 64'(exp_g));
                    exp_pending = 0;
                end else if (start) begin
                    chk("grant_without_request", 64'(g), 64'd3);
                end
                if (start) begin
                    txn_active = 1; txn_kind = g; grant_log.push_back(g);
                    tb_last = (g == 0) ? 0 : 1;
                end
                if (was_idle && !start) begin
                    chk("idle_quiet", 64'(quiet_vec()), 64'd0);
                    r0 = m0_arvalid;
                    r1 = m1_arvalid || m1_awvalid;
                    if (r0 || r1) begin
                        exp_pending = 1;
                        if (r0 && (!r1 || tb_last == 1)) exp_g = 0;
                        else exp_g = m1_arvalid ? 1 : 2;
                    end
                end
                if (txn_active) begin
                    chk("one_outstanding", 64'(s_arvalid && s_awvalid), 64'd0);
                    case (txn_kind)
                        0: chk("m1_blocked", 64'({m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}), 64'd0);
                        1: chk("others_blocked", 64'({m0_arready, m0_rvalid, m1_awready, m1_wready, m1_bvalid}), 64'd0);
                        default: chk("rd_blocked", 64'({m0_arready, m0_rvalid, m1_arready, m1_rvalid}), 64'd0);
                    endcase
                end
                if (!was_idle) begin
                    if ((txn_kind != 2 && s_rvalid && s_rready && s_rlast) ||
                        (txn_kind == 2 && s_bvalid && s_bready))
                        txn_active = 0;
                end
            end
        end
    end

    task automatic m0_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int n;
        @(posedge clock); #1;
        m0_arvalid = 1; m0_araddr = a; m0_arid = id; m0_arlen = len; m0_arsize = 3'd2; m0_arburst = 2'b01;
        exp_ar0.push_back({2'b01, 3'd2, len, id, a});
        for (int i = 0; i <= int'(len); i++) exp_r0.push_back({(i == int'(len)), resp_of(a), id, rd_data(a, i)});
        n = 0;
        while (1) begin
            @(negedge clock);
            if (m0_arready) break;
            n++;
            if (n > 2000) begin chk("m0_ar_timeout", 64'(n), 64'd0); break; end
        end
        @(posedge clock); #1;
        m0_arvalid = 0; m0_araddr = 0; m0_arid = 0; m0_arlen = 0; m0_arsize = 0; m0_arburst = 0;
    endtask

    task automatic m1_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int n;
        @(posedge clock); #1;
        m1_arvalid = 1; m1_araddr = a; m1_arid = id; m1_arlen = len; m1_arsize = 3'd2; m1_arburst = 2'b01;
        exp_ar1.push_back({2'b01, 3'd2, len, id, a});
        for (int i = 0; i <= int'(len); i++) exp_r1.push_back({(i == int'(len)), resp_of(a), id, rd_data(a, i)});
        n = 0;
        while (1) begin
            @(negedge clock);
            if (m1_arready) break;
            n++;
            if (n > 2000) begin chk("m1_ar_timeout", 64'(n), 64'd0); break; end
        end
        @(posedge clock); #1;
        m1_arvalid = 0; m1_araddr = 0; m1_arid = 0; m1_arlen = 0; m1_arsize = 0; m1_arburst = 0;
    endtask

    task automatic m1_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        @(posedge clock); #1;
        m1_awvalid = 1; m1_awaddr = a; m1_awid = id; m1_awlen = len; m1_awsize = 3'd2; m1_awburst = 2'b01;
        exp_aw.push_back({2'b01, 3'd2, len, id, a});
        exp_b.push_back({resp_of(a), id});
        for (int i = 0; i <= int'(len); i++) exp_w.push_back({(i == int'(len)), 4'hF, wr_data(a, i)});
        fork
            begin
                int n = 0;
                while (1) begin
                    @(negedge clock);
                    if (m1_awready) break;
                    n++;
                    if (n > 2000) begin chk("aw_timeout", 64'(n), 64'd0); break; end
                end
                @(posedge clock); #1;
                m1_awvalid = 0; m1_awaddr = 0; m1_awid = 0; m1_awlen = 0; m1_awsize = 0; m1_awburst = 0;
            end
            begin
                for (int i = 0; i <= int'(len); i++) begin
                    int n = 0;
                    m1_wvalid = 1; m1_wdata = wr_data(a, i); m1_wstrb = 4'hF; m1_wlast = (i == int'(len));
                    while (1) begin
                        @(negedge clock);
                        if (m1_wready) break;
                        n++;
                        if (n > 2000) begin chk("w_timeout", 64'(n), 64'd0); break; end
                    end
                    @(posedge clock); #1;
                end
                m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_wlast = 0;
            end
        join
    endtask

    task automatic drain();
        int n = 0;
        while (!(exp_r0.size() == 0 && exp_r1.size() == 0 && exp_b.size() == 0 && !txn_active && !exp_pending)
               && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 5000) chk("drain_timeout", 64'(n), 64'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clock); #1;
        reset = 1;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset = 1;
        m0_arvalid = 0; m0_araddr = 0; m0_arid = 0; m0_arlen = 0; m0_arsize = 0; m0_arburst = 0;
        m1_arvalid = 0; m1_araddr = 0; m1_arid = 0; m1_arlen = 0; m1_arsize = 0; m1_arburst = 0;
        m1_awvalid = 0; m1_awaddr = 0; m1_awid = 0; m1_awlen = 0; m1_awsize = 0; m1_awburst = 0;
        m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_wlast = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_quiet", 64'(quiet_vec()), 64'd0);
        @(posedge clock); #1;
        reset = 0;

        // lone m0 read of the timer word
        grant_log.delete();
        m0_read(32'h1001_0000, 4'h3, 8'd0);
        drain();
        chk("lone_read_grants", 64'(grant_log.size()), 64'd1);
        if (grant_log.size() > 0) chk("lone_read_master", 64'(grant_log[0]), 64'd0);

        // simultaneous reads after reset alternate m0, m1
        pulse_reset(2);
        grant_log.delete();
        for (int r = 0; r < 4; r++) begin
            fork
                m0_read(32'h2000_0000 + 32'(r * 16), 4'(r), 8'd0);
                m1_read(32'h3000_0000 + 32'(r * 16), 4'(8 + r), 8'd1);
            join
            drain();
        end
        chk("rr_grants", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < grant_log.size() && i < 8; i++) chk("rr_order", 64'(grant_log[i]), 64'(i % 2));

        // m1 read beats m1 write
        grant_log.delete();
        fork
            m1_read(32'h4000_0004, 4'h9, 8'd0);
            m1_write(32'h4000_0008, 4'hA, 8'd1);
        join
        drain();
        chk("rw_grants", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) chk("rw_order", 64'({grant_log[0][1:0], grant_log[1][1:0]}), 64'h6);

        // m1 write holds off a following m0 read
        grant_log.delete();
        fork
            m1_write(32'h1001_0000, 4'hB, 8'd0);
            begin @(posedge clock); m0_read(32'h1001_0010, 4'h4, 8'd0); end
        join
        drain();
        chk("wr_then_rd_grants", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) chk("wr_then_rd_order", 64'({grant_log[0][1:0], grant_log[1][1:0]}), 64'h8);

        // four-beat m0 burst blocks m1
        grant_log.delete();
        fork
            m0_read(32'h5000_0100, 4'h5, 8'd3);
            begin @(posedge clock); m1_read(32'h5000_0200, 4'hC, 8'd0); end
        join
        drain();
        chk("burst_grants", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) chk("burst_order", 64'({grant_log[0][1:0], grant_log[1][1:0]}), 64'h1);

        // reset while RD1 awaits read data
        slave_rhold = 1;
        m1_read(32'h6000_0000, 4'hD, 8'd0);
        repeat (2) @(negedge clock);
        chk("rd1_waiting", 64'({m1_rvalid, m0_arready, m0_rvalid}), 64'd0);
        pulse_reset(1);
        exp_r1.delete();
        @(negedge clock);
        chk("abort_quiet", 64'(quiet_vec()), 64'd0);
        slave_rhold = 0;
        grant_log.delete();
        m0_read(32'h6000_0040, 4'h6, 8'd1);
        drain();
        chk("post_abort_grants", 64'(grant_log.size()), 64'd1);

        // randomized mix
        for (int it = 0; it < 40; it++) begin
            bit d0, d1, d2;
            int w0, w1, w2;
            logic [31:0] a0, a1, a2;
            logic [3:0] i0, i1, i2;
            logic [7:0] l0, l1, l2;
            d0 = ($urandom_range(0, 3) != 0); d1 = ($urandom_range(0, 2) != 0); d2 = ($urandom_range(0, 2) != 0);
            w0 = $urandom_range(0, 3); w1 = $urandom_range(0, 3); w2 = $urandom_range(0, 3);
            a0 = $urandom & 32'hFFFF_FFFC; a1 = $urandom & 32'hFFFF_FFFC; a2 = $urandom & 32'hFFFF_FFFC;
            i0 = 4'($urandom_range(0, 7)); i1 = 4'($urandom_range(8, 15)); i2 = 4'($urandom_range(0, 15));
            l0 = 8'($urandom_range(0, 3)); l1 = 8'($urandom_range(0, 3)); l2 = 8'($urandom_range(0, 2));
            fork
                begin if (d0) begin repeat (w0) @(posedge clock); m0_read(a0, i0, l0); end end
                begin if (d1) begin repeat (w1) @(posedge clock); m1_read(a1, i1, l1); end end
                begin if (d2) begin repeat (w2) @(posedge clock); m1_write(a2, i2, l2); end end
            join
            drain();
        end

        chk("leftover_requests", 64'(exp_ar0.size() + exp_ar1.size() + exp_aw.size() + exp_w.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
